// File: rtl/spdif_transmitter.sv
// IEC 60958 consumer transmitter: 16-bit stereo frames, preambles, parity and biphase-mark coding.
// Define SPDIF_CSTAT_EN to send channel-status bits 2, 24 and 25 (copy permitted, 32 kHz).
module spdif_transmitter #(
    parameter int unsigned DIV     = 4,
    parameter int unsigned CS_BITS = 192
) (
    input  logic        mclk,
    input  logic        rst,
    input  logic [31:0] data,
    output logic        drq,
    output logic        spdif_out,
    output logic        block_start
);
    localparam int unsigned DivW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int unsigned FrW  = (CS_BITS > 1) ? $clog2(CS_BITS) : 1;

    logic [DivW-1:0] r_div_cnt;
    logic [5:0]      r_cell;
    logic            r_side;
    logic [FrW-1:0]  r_frame;
    logic [31:0]     r_buf;
    logic            r_drq;
    logic            r_line;
    logic            r_pinv;
    logic            r_par;
    logic            r_block_start;

    logic        w_cell_en;
    logic        w_latch;
    logic [4:0]  w_slot;
    logic [3:0]  w_aidx;
    logic [15:0] w_sample;
    logic        w_cbit;
    logic        w_bit;
    logic [7:0]  w_pre;
    logic        w_pinv;
    logic        w_line_d;

    assign w_cell_en = (r_div_cnt == DivW'(DIV - 1));
    assign w_latch   = w_cell_en && (r_cell == 6'd0) && !r_side;
    assign w_slot    = r_cell[5:1];
    assign w_aidx    = 4'(w_slot - 5'd12);
    assign w_sample  = r_side ? r_buf[15:0] : r_buf[31:16];

`ifdef SPDIF_CSTAT_EN
    assign w_cbit = (r_frame == FrW'(2)) || (r_frame == FrW'(24)) || (r_frame == FrW'(25));
`else
    assign w_cbit = 1'b0;
`endif

    always_comb begin
        w_bit = 1'b0;
        if (w_slot >= 5'd12 && w_slot <= 5'd27) begin
            w_bit = w_sample[w_aidx];
        end else if (w_slot == 5'd30) begin
            w_bit = w_cbit;
        end else if (w_slot == 5'd31) begin
            w_bit = r_par;
        end
    end

    always_comb begin
        if (r_side) begin
            w_pre = 8'b11100100;
        end else if (r_frame == '0) begin
            w_pre = 8'b11101000;
        end else begin
            w_pre = 8'b11100010;
        end
    end

    // Preamble polarity is frozen at cell 0 from the level the previous subframe ended on.
    assign w_pinv = (r_cell == 6'd0) ? r_line : r_pinv;

    always_comb begin
        if (w_slot < 5'd4) begin
            w_line_d = w_pre[~r_cell[2:0]] ^ w_pinv;
        end else if (!r_cell[0]) begin
            w_line_d = ~r_line;
        end else begin
            w_line_d = r_line ^ w_bit;
        end
    end

    always_ff @(posedge mclk) begin
        if (rst) begin
            r_div_cnt     <= '0;
            r_cell        <= '0;
            r_side        <= 1'b0;
            r_frame       <= '0;
            r_buf         <= '0;
            r_drq         <= 1'b0;
            r_line        <= 1'b0;
            r_pinv        <= 1'b0;
            r_par         <= 1'b0;
            r_block_start <= 1'b0;
        end else begin
            r_div_cnt <= w_cell_en ? '0 : r_div_cnt + DivW'(1);
            r_drq     <= w_latch;
            if (w_latch) begin
                r_buf <= data;
            end
            if (w_cell_en) begin
                r_line        <= w_line_d;
                r_block_start <= (r_frame == '0) && !r_side;
                if (r_cell == 6'd0) begin
                    r_pinv <= r_line;
                end
                // Parity folds in each bit once per slot; slot 4 restarts it.
                if (r_cell[0]) begin
                    if (w_slot == 5'd4) begin
                        r_par <= w_bit;
                    end else if (w_slot != 5'd31) begin
                        r_par <= r_par ^ w_bit;
                    end
                end
                r_cell <= r_cell + 6'd1;
                if (r_cell == 6'd63) begin
                    r_side <= ~r_side;
                    if (r_side) begin
                        r_frame <= (r_frame == FrW'(CS_BITS - 1)) ? '0 : r_frame + FrW'(1);
                    end
                end
            end
        end
    end

    assign drq         = r_drq;
    assign spdif_out   = r_line;
    assign block_start = r_block_start;

endmodule

// File: tb/tb_spdif_transmitter.sv
// Bench for spdif_transmitter: a subframe-level model checked every cycle, plus a BMC decoder
// on the captured line with literal expectations. Honours SPDIF_CSTAT_EN for channel status.
module tb_spdif_transmitter;
    localparam int DIV       = 2;
    localparam int CS_BITS   = 192;
    localparam int FRAME_CYC = DIV * 128;
    localparam logic [7:0] PRE_B = 8'b11101000;
    localparam logic [7:0] PRE_M = 8'b11100010;
    localparam logic [7:0] PRE_W = 8'b11100100;
`ifdef SPDIF_CSTAT_EN
    localparam logic [191:0] CS_EXP = 192'h0300_0004;
`else
    localparam logic [191:0] CS_EXP = 192'h0;
`endif

    logic        mclk = 1'b0;
    logic        rst  = 1'b1;
    logic [31:0] data = 32'h0;
    logic        drq;
    logic        spdif_out;
    logic        block_start;

    spdif_transmitter #(.DIV(DIV), .CS_BITS(CS_BITS)) dut (
        .mclk        (mclk),
        .rst         (rst),
        .data        (data),
        .drq         (drq),
        .spdif_out   (spdif_out),
        .block_start (block_start)
    );

    always #5 mclk = ~mclk;

    int n_chk  = 0;
    int n_pass = 0;
    int phase  = 0;

    // Model state, updated on posedge, read on negedge.
    int          m_n = 0;
    int          m_k = 0;
    int          m_cell = 0;
    int          m_side = 0;
    int          m_frame = 0;
    int          m_phase = 0;
    int          lat_cnt = 0;
    bit          m_tick = 1'b0;
    bit          m_armed = 1'b0;
    logic        m_line = 1'b0;
    logic [31:0] m_word = 32'h0;
    logic        m_cells [64];
    logic        exp_spdif = 1'b0;
    logic        exp_drq = 1'b0;
    logic        exp_bs = 1'b0;

    task automatic check(input bit ok, input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        n_chk++;
        if (ok) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    endtask

    function automatic logic cs_exp(input int f);
        return CS_EXP[f];
    endfunction

    initial begin : model
        logic        bits [32];
        logic [15:0] smp;
        logic [7:0]  pre;
        logic        lvl;
        int          ones;
        forever begin
            @(posedge mclk);
            m_tick  = 1'b0;
            exp_drq = 1'b0;
            if (rst) begin
                m_armed   = 1'b1;
                m_n       = 0;
                m_line    = 1'b0;
                exp_spdif = 1'b0;
                exp_bs    = 1'b0;
            end else begin
                m_n++;
                if (m_n % DIV == 0) begin
                    m_k     = m_n / DIV - 1;
                    m_cell  = m_k % 64;
                    m_side  = (m_k / 64) % 2;
                    m_frame = (m_k / 128) % CS_BITS;
                    if (m_cell == 0) begin
                        if (m_side == 0) begin
                            m_word  = data;
                            m_phase = phase;
                            exp_drq = 1'b1;
                            lat_cnt++;
                        end
                        smp = (m_side != 0) ? m_word[15:0] : m_word[31:16];
                        for (int s = 0; s < 32; s++) bits[s] = 1'b0;
                        for (int i = 0; i < 16; i++) bits[12+i] = smp[i];
                        bits[30] = cs_exp(m_frame);
                        ones = 0;
                        for (int s = 4; s < 31; s++) ones += int'(bits[s]);
                        bits[31] = (ones % 2 == 1);
                        pre = (m_side != 0) ? PRE_W : ((m_frame == 0) ? PRE_B : PRE_M);
                        for (int i = 0; i < 8; i++) m_cells[i] = pre[7-i] ^ m_line;
                        lvl = m_cells[7];
                        for (int s = 4; s < 32; s++) begin
                            lvl = ~lvl;
                            m_cells[2*s] = lvl;
                            lvl = lvl ^ bits[s];
                            m_cells[2*s+1] = lvl;
                        end
                    end
                    exp_spdif = m_cells[m_cell];
                    m_line    = exp_spdif;
                    exp_bs    = (m_frame == 0) && (m_side == 0);
                    m_tick    = 1'b1;
                end
            end
        end
    end

    initial begin : cmp
        logic        cap [64];
        logic        cap_bs [64];
        logic        db [32];
        logic        cs_l [CS_BITS];
        logic [191:0] cs_vec;
        logic [7:0]  raw;
        logic [7:0]  norm;
        logic [7:0]  expp;
        logic [15:0] smp;
        logic        prev_bs;
        bit          tog_ok;
        bit          bs_all;
        int          ones;
        int          mids;
        int          cs_cnt;
        int          prev_drq_n;
        int          prev_bs_n;
        int          bs_len;
        prev_drq_n = 1 << 30;
        prev_bs_n  = 1 << 30;
        prev_bs    = 1'b0;
        bs_len     = 0;
        cs_cnt     = 0;
        cs_vec     = '0;
        forever begin
            @(negedge mclk);
            if (m_armed) begin
                check(spdif_out === exp_spdif, "spdif_out", 64'(spdif_out), 64'(exp_spdif));
                check(drq === exp_drq, "drq", 64'(drq), 64'(exp_drq));
                check(block_start === exp_bs, "block_start", 64'(block_start), 64'(exp_bs));

                if (drq === 1'b1) begin
                    if (prev_drq_n < m_n)
                        check(m_n - prev_drq_n == FRAME_CYC, "drq period", m_n - prev_drq_n,
                              FRAME_CYC);
                    else
                        check(m_n >= 1 && m_n <= DIV, "first drq latency", m_n, DIV);
                    prev_drq_n = m_n;
                end

                if (block_start === 1'b1) begin
                    if (!prev_bs) begin
                        if (prev_bs_n < m_n)
                            check(m_n - prev_bs_n == CS_BITS * FRAME_CYC, "block_start period",
                                  m_n - prev_bs_n, CS_BITS * FRAME_CYC);
                        prev_bs_n = m_n;
                        bs_len = 0;
                    end
                    bs_len++;
                end else if (prev_bs) begin
                    check(bs_len == 64 * DIV, "block_start width", bs_len, 64 * DIV);
                end
                prev_bs = (block_start === 1'b1);

                if (m_tick) begin
                    cap[m_cell]    = spdif_out;
                    cap_bs[m_cell] = block_start;
                    if (m_cell == 63) begin
                        for (int i = 0; i < 8; i++) raw[7-i] = cap[i];
                        norm = cap[0] ? raw : ~raw;
                        expp = (m_side != 0) ? PRE_W : ((m_frame == 0) ? PRE_B : PRE_M);
                        check(norm == expp, "preamble", norm, expp);
                        tog_ok = 1'b1;
                        ones = 0;
                        mids = 0;
                        for (int s = 4; s < 32; s++) begin
                            if (cap[2*s] == cap[2*s-1]) tog_ok = 1'b0;
                            db[s] = cap[2*s] ^ cap[2*s+1];
                            ones += int'(db[s]);
                            if (s < 30) mids += int'(db[s]);
                        end
                        check(tog_ok, "slot-start toggle", 64'(tog_ok), 64'd1);
                        check(ones % 2 == 0, "even parity", ones, 0);
                        for (int i = 0; i < 16; i++) smp[i] = db[12+i];

                        if (m_k / 64 == 0) begin
                            check(raw == PRE_B, "first 8 cells", raw, PRE_B);
                            bs_all = 1'b1;
                            for (int i = 0; i < 64; i++) if (cap_bs[i] !== 1'b1) bs_all = 1'b0;
                            check(bs_all, "block_start over first subframe", 64'(bs_all), 64'd1);
                        end
                        if (m_phase == 1) begin
                            check(mids == 0, "silence one toggle per slot", mids, 0);
                            check(db[31] == cs_exp(m_frame), "silence parity", 64'(db[31]),
                                  64'(cs_exp(m_frame)));
                        end
                        if (m_phase == 2) begin
                            check(smp == ((m_side != 0) ? 16'h0001 : 16'h8000), "0x80000001 sample",
                                  smp, (m_side != 0) ? 16'h0001 : 16'h8000);
                            check(db[31] == 1'b1, "0x80000001 parity", 64'(db[31]), 64'd1);
                        end
                        if (m_phase == 5 && m_k / 128 == 0)
                            check(smp == ((m_side != 0) ? 16'hABCD : 16'h1234),
                                  "post-reset sample", smp, (m_side != 0) ? 16'hABCD : 16'h1234);

                        if (m_side == 0) begin
                            if (m_frame == 0) cs_cnt = 0;
                            cs_l[m_frame] = db[30];
                        end else begin
                            check(cs_l[m_frame] === db[30] && db[30] === cs_exp(m_frame),
                                  "channel-status bit", {cs_l[m_frame], db[30]},
                                  {2{cs_exp(m_frame)}});
                            cs_vec[m_frame] = db[30];
                            cs_cnt++;
                            if (m_frame == CS_BITS - 1 && cs_cnt == CS_BITS)
                                check(cs_vec == CS_EXP, "channel-status block", cs_vec[63:0],
                                      CS_EXP[63:0]);
                        end
                    end
                end
            end
        end
    end

    task automatic wait_lat(input int target);
        int budget;
        budget = (target - lat_cnt + 2) * FRAME_CYC + 100;
        while (lat_cnt < target && budget > 0) begin
            @(negedge mclk);
            budget--;
        end
        if (lat_cnt < target) check(1'b0, "latch wait timeout", lat_cnt, target);
    endtask

    initial begin : drive
        int budget;
        repeat (3) @(negedge mclk);
        phase = 1;
        rst   = 1'b0;
        wait_lat(4);
        data  = 32'h8000_0001;
        phase = 2;
        wait_lat(8);
        phase = 3;
        for (int i = 0; i < (20 * FRAME_CYC) / 100; i++) begin
            data = $urandom;
            repeat (100) @(negedge mclk);
        end
        data  = 32'h0;
        phase = 4;
        wait_lat(CS_BITS + 2);

        budget = 70 * FRAME_CYC;
        while (!(m_tick && m_frame == 57 && m_side == 0 && m_cell == 30) && budget > 0) begin
            @(negedge mclk);
            budget--;
        end
        if (budget == 0) check(1'b0, "frame 57 wait timeout", m_frame, 57);
        rst   = 1'b1;
        data  = 32'h1234_ABCD;
        phase = 5;
        @(negedge mclk);
        check(spdif_out === 1'b0, "reset spdif_out", 64'(spdif_out), 64'd0);
        check(drq === 1'b0, "reset drq", 64'(drq), 64'd0);
        check(block_start === 1'b0, "reset block_start", 64'(block_start), 64'd0);
        rst = 1'b0;
        wait_lat(lat_cnt + 3);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d so far", n_pass, n_chk);
        $fatal(1);
    end

endmodule

// File: doc/spdif_transmitter.md
Name: spdif_transmitter

Overview:
- Consumes the 32-bit {left,right} frame word from the DAC decoder and drives a single-wire IEC 60958 (S/PDIF) consumer output.
- Runs in parallel with the I2S serializer on the same data word and drq-style request.
- Lets the MT-32 feed an optical or coax receiver directly, without an external DIT chip.
- Performs subframe assembly, preamble insertion, channel-status sequencing over a 192-frame block, even parity and biphase-mark coding.

Parameters:
- DIV, 4: mclk cycles per biphase cell; 16.384 MHz / 4 = 4.096 MHz cell rate, which gives a 32 kHz frame rate.
- CS_BITS, 192: frames per channel-status block.

Ports:
- mclk  input  1  master clock, 16.384 MHz, sole clock.
- rst  input  1  reset: one clock; reset is synchronous and active-high.
- data  input  32  {left[15:0], right[15:0]}, two's complement; sampled at frame start.
- drq  output  1  one-mclk pulse: the frame word has been latched and the next word may be presented.
- spdif_out  output  1  biphase-mark coded S/PDIF line.
- block_start  output  1  high for the 64 cells of the B-preambled left subframe (debug).

Behaviour:
- Reset values (rst high at a mclk edge): spdif_out=0, drq=0, block_start=0, all counters 0, frame buffer 0, previous-line-level 0. Reset applies mid-frame with no completion of the current cell.
- Cell enable: div_cnt counts 0..DIV-1; cell_en is asserted when div_cnt==DIV-1. All line and counter state advances only on cell_en.
- Counters: cell 0..63 within a subframe (slot = cell>>1), side L/R, frame 0..CS_BITS-1. The order is L then R; frame wraps 191->0.
- Frame latch: on the cell_en with cell==0 and side==L, buf <= data. drq is high for exactly the next mclk cycle, so the period is DIV*128 = 512 mclk. The first latch occurs on the first cell_en after rst deasserts, and frame 0 starts with B.
- Subframe slots, 32 per subframe:
  - 0-3: preamble. B on L of frame 0, M on other L, W on R.
  - 4-11: zero (aux and audio LSB extension).
  - 12-27: 16-bit sample, LSB first. L uses buf[31:16], R uses buf[15:0].
  - 28: V=0.
  - 29: U=0.
  - 30: C = channel-status bit[frame], same value for both subframes.
  - 31: P, chosen so slots 4-31 carry an even number of ones.
- Preamble cells, for previous line level 0: B=11101000, M=11100010, W=11100100. The pattern is emitted inverted when the previous level is 1, and is not BMC coded.
- BMC, slots 4-31:
  - Level toggles at every slot start (even cell).
  - Level toggles again at mid-slot (odd cell) iff the bit is 1.
  - spdif_out is registered and changes only on a cell_en edge.
- Parity is computed incrementally (toggle flag on each 1 bit in slots 4-30, cleared at slot 4), not combinationally over the whole word.
- block_start = (frame==0 && side==L), registered alongside spdif_out.
- data changing at any time other than the latch edge has no effect on the current frame.
- Arithmetic: all counters wrap cleanly. There is no sample arithmetic; samples are transmitted bit-exact.

Optional Feature:
- Macro: SPDIF_CSTAT_EN.
- Defined: channel-status bit 2=1 (copy permitted) and bits 24,25 = 1,1 (32 kHz, IEC code 1100). All other bits are 0, including bit 0 (consumer) and bit 1 (audio PCM).
- Undefined: all 192 C bits are 0. The bit-selection logic is removed and slot 30 is constant 0.

Test Plan:
- Reset release, data=0x0000_0000:
  - first drq pulse within DIV mclk cycles;
  - drq period exactly 512 mclk;
  - first 8 cells = 11101000 (B);
  - block_start high for 64 cells every 192*512 mclk.
- Silence decode: data=0x0000_0000 held:
  - R subframe preamble 11100100 or inverse (W);
  - L preambles of frames 1..191 are M;
  - all data slots show exactly one toggle each;
  - P=0.
- data=0x8000_0001:
  - L: slot 27=1, other audio slots 0, P=1;
  - R: slot 12=1, P=1;
  - the reference BMC decoder in the bench recovers 0x8000 and 0x0001.
- Change data every 100 mclk (asynchronous to the latch): each transmitted frame equals the value present on the drq-preceding latch edge; no mixed L/R words.
- Assert rst for 1 mclk at frame 57, cell 30:
  - spdif_out=0 the next cycle;
  - after release, the frame counter restarts at 0 with a B preamble;
  - buf is reloaded from the current data.
- SPDIF_CSTAT_EN defined, collect slot-30 bits over 192 frames: bits 2, 24, 25 = 1, all others 0, identical in L and R. Undefined: all 0.
